// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, timing helper and scheduler state type
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int bit_cycles(input int freq, input int rate);
    return freq / rate;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, scans from ptr+1 upward with wrap
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      index,
  output logic            any
);

  // first requester found after ptr wins; later hits are masked by any
  always_comb begin
    int pos;
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos = (int'(ptr) + i) % NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!any && (k == pos) && req[k]) begin
          any    = 1'b1;
          gnt[k] = 1'b1;
          index  = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin byte scheduler for one uart_tx; optional packet lock via UART_TX_ARB_PKT_LOCK_EN
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int FREQ     = 1_000_000,
  parameter int RATE     = 115_200,
  parameter int NREQ     = 4,
  parameter int GAP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   i_vld,
  input  logic [8*NREQ-1:0] i_data,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_rdy,
  output logic [7:0]        o_data,
  output logic              o_vld,
  output logic [2:0]        o_gnt_id,
  output logic              o_busy
);

  localparam int BIT_CYCLES   = bit_cycles(FREQ, RATE);
  localparam int FRAME_CYCLES = (UART_FRAME_BITS + GAP_BITS) * BIT_CYCLES;
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  if (BIT_CYCLES < 1) begin : g_bad_rate
    $error("uart_tx_arb: RATE exceeds FREQ, BIT_CYCLES would be zero");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arb: NREQ must be within 2..8");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ptr;
  logic [NREQ-1:0]  scan_req;
  logic [NREQ-1:0]  pick_gnt;
  logic [2:0]       pick_idx;
  logic             pick_any;
  logic [7:0]       pick_data;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (scan_req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic       locked;
  logic [2:0] lock_id;
  logic       pick_last;

  // while a packet is open only its owner is visible to the picker
  always_comb begin
    scan_req = i_vld;
    if (locked) begin
      for (int k = 0; k < NREQ; k++) begin
        if (3'(k) != lock_id) scan_req[k] = 1'b0;
      end
    end
  end

  // last-byte flag of the requester being picked
  always_comb begin
    pick_last = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == 3'(k)) pick_last = i_last[k];
    end
  end

  // lock opens on a non-final byte and closes on the final one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (state == IDLE && pick_any) begin
      locked  <= ~pick_last;
      lock_id <= pick_idx;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^i_last;

  // byte-granular round-robin: every valid requester competes
  always_comb begin
    scan_req = i_vld;
  end
`endif

  // byte of the requester being picked
  always_comb begin
    pick_data = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == 3'(k)) pick_data = i_data[8*k +: 8];
    end
  end

  assign o_rdy = (state == IDLE) ? pick_gnt : '0;

  // scheduler FSM: grant in IDLE, then hold off for one full frame plus gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 3'(NREQ - 1);
      o_vld    <= 1'b0;
      o_data   <= 8'h00;
      o_gnt_id <= '0;
      o_busy   <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            o_data   <= pick_data;
            o_gnt_id <= pick_idx;
            ptr      <= pick_idx;
            o_vld    <= 1'b1;
            o_busy   <= 1'b1;
            cnt      <= CNT_LOAD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb at default parameters
module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   i_vld = '0;
  logic [8*NREQ-1:0] i_data = '0;
  logic [NREQ-1:0]   i_last = '0;
  logic [NREQ-1:0]   o_rdy;
  logic [7:0]        o_data;
  logic              o_vld;
  logic [2:0]        o_gnt_id;
  logic              o_busy;

  uart_tx_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_vld    (i_vld),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_rdy    (o_rdy),
    .o_data   (o_data),
    .o_vld    (o_vld),
    .o_gnt_id (o_gnt_id),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_d[NREQ][$];
  logic       src_l[NREQ][$];
  logic [NREQ-1:0] mask = '0;
  logic [NREQ-1:0] hs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int test_id = 0;
  int prev_test = -1;
  int prev_cyc = 0;
  int busy_run = 0;
  int last_busy = 0;
  bit gap_chk = 1'b0;
  int s0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic src(input int k, input logic [7:0] d, input logic l);
    src_d[k].push_back(d);
    src_l[k].push_back(l);
  endtask

  task automatic expect_b(input logic [2:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    for (int k = 0; k < NREQ; k++) begin
      src_d[k].delete();
      src_l[k].delete();
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    flush();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_id++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() > 0 || o_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 3000, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_vld && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 500, 1'b1);
  endtask

  // requester model: holds each byte until the handshake is seen
  initial begin
    forever begin
      @(negedge clk);
      hs = rst_n ? (i_vld & o_rdy) : '0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k] && src_d[k].size() > 0) begin
          void'(src_d[k].pop_front());
          void'(src_l[k].pop_front());
        end
        i_vld[k]         = (src_d[k].size() > 0) && !mask[k];
        i_data[8*k +: 8] = (src_d[k].size() > 0) ? src_d[k][0] : 8'h00;
        i_last[k]        = (src_l[k].size() > 0) ? src_l[k][0] : 1'b0;
      end
    end
  end

  // output monitor: scoreboard pop, strobe spacing, no ready while busy
  always @(negedge clk) begin
    cyc++;
    if (o_busy) begin
      busy_run++;
      chk("rdy_in_hold", 32'(o_rdy), 0);
    end else if (busy_run > 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (o_vld) begin
      strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_id", 32'(o_gnt_id), 32'(e.id));
        chk("strobe_data", 32'(o_data), 32'(e.data));
      end
      if (gap_chk && prev_test == test_id) chk("strobe_gap", cyc - prev_cyc, 89);
      prev_test = test_id;
      prev_cyc  = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(o_vld), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_gnt", 32'(o_gnt_id), 0);
    chk("rst_rdy", 32'(o_rdy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_id++;

    // single byte from requester 0
    @(negedge clk);
    s0 = strobes;
    src(0, 8'h6A, 1'b1);
    expect_b(3'd0, 8'h6A);
    drain("single_drain");
    chk("single_busy_len", last_busy, 88);
    chk("single_count", strobes - s0, 1);

    // all four valid at once
    do_reset();
    gap_chk = 1'b1;
    @(negedge clk);
    s0 = strobes;
    src(0, 8'h11, 1'b1);
    src(1, 8'h22, 1'b1);
    src(2, 8'h33, 1'b1);
    src(3, 8'h44, 1'b1);
    expect_b(3'd0, 8'h11);
    expect_b(3'd1, 8'h22);
    expect_b(3'd2, 8'h33);
    expect_b(3'd3, 8'h44);
    drain("all_drain");
    repeat (200) @(negedge clk);
    chk("all_count", strobes - s0, 4);

    // requesters 0 and 2 alternate
    do_reset();
    @(negedge clk);
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      src(0, 8'hA0 + 8'(i), 1'b1);
      src(2, 8'hC0 + 8'(i), 1'b1);
      expect_b(3'd0, 8'hA0 + 8'(i));
      expect_b(3'd2, 8'hC0 + 8'(i));
    end
    drain("alt_drain");
    chk("alt_count", strobes - s0, 6);

    // reset in the middle of a frame
    do_reset();
    gap_chk = 1'b0;
    @(negedge clk);
    src(0, 8'h55, 1'b1);
    expect_b(3'd0, 8'h55);
    wait_strobe("rst_mid_strobe");
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(o_busy), 0);
    chk("rst_mid_vld", 32'(o_vld), 0);
    flush();
    s0 = strobes;
    src(1, 8'h71, 1'b1);
    src(3, 8'h73, 1'b1);
    expect_b(3'd1, 8'h71);
    expect_b(3'd3, 8'h73);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_id++;
    drain("rst_mid_drain");
    chk("rst_mid_count", strobes - s0, 2);

    // requester 3 withdraws during a frame
    do_reset();
    @(negedge clk);
    s0 = strobes;
    src(2, 8'h2B, 1'b1);
    expect_b(3'd2, 8'h2B);
    wait_strobe("wd_strobe");
    @(negedge clk);
    src(3, 8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    mask[3] = 1'b1;
    src_d[3].delete();
    src_l[3].delete();
    repeat (3) @(negedge clk);
    mask[3] = 1'b0;
    src(0, 8'h0D, 1'b1);
    expect_b(3'd0, 8'h0D);
    drain("wd_drain");
    chk("wd_count", strobes - s0, 2);

    // multi-byte packet from requester 1 against a pending requester 0
    do_reset();
    @(negedge clk);
    s0 = strobes;
    src(0, 8'hE0, 1'b1);
    expect_b(3'd0, 8'hE0);
    wait_strobe("pkt_strobe");
    src(1, 8'hB1, 1'b0);
    src(1, 8'hB2, 1'b0);
    src(1, 8'hB3, 1'b1);
    src(0, 8'hE1, 1'b1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
    expect_b(3'd1, 8'hB1);
    expect_b(3'd1, 8'hB2);
    expect_b(3'd1, 8'hB3);
    expect_b(3'd0, 8'hE1);
`else
    expect_b(3'd1, 8'hB1);
    expect_b(3'd0, 8'hE1);
    expect_b(3'd1, 8'hB2);
    expect_b(3'd1, 8'hB3);
`endif
    drain("pkt_drain");
    chk("pkt_count", strobes - s0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
